// File: rtl/traffic_light_ctrl_if.sv
// Lamp/status bundle between the traffic light controller and its environment.
// The controller takes the slave view; the lamp/buzzer side takes the master view.
interface traffic_light_ctrl_if;
  logic [2:0] lamp_ok;
  logic       manual_red;
  logic [1:0] color;
  logic [2:0] unable;
  logic [6:0] sec_left;
  logic       tick;

  modport master (
    output lamp_ok, manual_red,
    input  color, unable, sec_left, tick
  );

  modport slave (
    input  lamp_ok, manual_red,
    output color, unable, sec_left, tick
  );
endinterface

// File: rtl/traffic_light_ctrl.sv
// Traffic light sequencer: 1-second prescaler, GREEN/YELLOW/RED phase timer,
// debounced lamp-failure flags and an absorbing DARK state when all lamps fail.
module traffic_light_ctrl #(
  parameter int unsigned TICK_DIV   = 10_000_000,
  parameter int unsigned GREEN_SEC  = 30,
  parameter int unsigned YELLOW_SEC = 3,
  parameter int unsigned RED_SEC    = 20
) (
  input  logic                clk,
  input  logic                rst,
  traffic_light_ctrl_if.slave bus
);

  localparam logic [1:0] ST_GREEN  = 2'd0;
  localparam logic [1:0] ST_YELLOW = 2'd1;
  localparam logic [1:0] ST_RED    = 2'd2;
  localparam logic [1:0] ST_DARK   = 2'd3;

  localparam int unsigned   PW       = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  localparam logic [6:0] GREEN_LEN  = 7'(GREEN_SEC);
  localparam logic [6:0] YELLOW_LEN = 7'(YELLOW_SEC);
  localparam logic [6:0] RED_LEN    = 7'(RED_SEC);

  logic [PW-1:0] prescaler;
  logic          tick;
  logic [1:0]    state, state_nxt;
  logic [1:0]    color_q, color_nxt;
  logic [6:0]    sec_left_q, sec_nxt;
  logic [2:0]    unable_q, unable_nxt;
  logic [2:0]    bad_prev, bad_now;

  assign tick         = (prescaler == PRE_LAST);
  assign bus.tick     = tick;
  assign bus.color    = color_q;
  assign bus.sec_left = sec_left_q;
  assign bus.unable   = unable_q;
  assign bad_now      = ~bus.lamp_ok;

  always_comb begin
    unable_nxt = unable_q;
    state_nxt  = state;
    sec_nxt    = sec_left_q;
    if (tick) begin
      // A lamp is declared failed only after two consecutive bad tick samples.
      unable_nxt = unable_q | (bad_now & bad_prev);
      if (state != ST_DARK) begin
        if (unable_nxt == '1) begin
          state_nxt = ST_DARK;
          sec_nxt   = '0;
        end else begin
          unique case (state)
            ST_GREEN: begin
              if (bus.manual_red || sec_left_q <= 7'd1) begin
                state_nxt = ST_YELLOW;
                sec_nxt   = YELLOW_LEN;
              end else begin
                sec_nxt = sec_left_q - 7'd1;
              end
            end
            ST_YELLOW: begin
              if (sec_left_q <= 7'd1) begin
                state_nxt = ST_RED;
                sec_nxt   = RED_LEN;
              end else begin
                sec_nxt = sec_left_q - 7'd1;
              end
            end
            ST_RED: begin
              if (sec_left_q <= 7'd1) begin
                state_nxt = ST_GREEN;
                sec_nxt   = GREEN_LEN;
              end else begin
                sec_nxt = sec_left_q - 7'd1;
              end
            end
            default: begin
              state_nxt = ST_DARK;
              sec_nxt   = '0;
            end
          endcase
        end
      end
    end
  end

  always_comb begin
    unique case (state_nxt)
      ST_GREEN:  color_nxt = 2'b01;
      ST_YELLOW: color_nxt = 2'b10;
      ST_RED:    color_nxt = 2'b11;
      default:   color_nxt = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prescaler  <= '0;
      state      <= ST_GREEN;
      color_q    <= 2'b01;
      sec_left_q <= GREEN_LEN;
      unable_q   <= '0;
      bad_prev   <= '0;
    end else begin
      prescaler  <= tick ? '0 : prescaler + 1'b1;
      state      <= state_nxt;
      color_q    <= color_nxt;
      sec_left_q <= sec_nxt;
      unable_q   <= unable_nxt;
      if (tick) bad_prev <= bad_now;
    end
  end

endmodule
